// File: rtl/fp32_pkg.sv
// Shared binary32 constants and classification helpers for the fp32 datapath blocks.
package fp32_pkg;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == FP32_EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

endpackage

// File: rtl/fp32_max2.sv
// Combinational binary32 max with sign-magnitude ordering; ties (including +0/-0) return a.
// Zero latency, no flow control.
module fp32_max2
  import fp32_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic b_wins;

  always_comb begin
    b_wins = 1'b0;
    if (is_zero(a_i) && is_zero(b_i)) begin
      b_wins = 1'b0;
    end else if (a_i[31] != b_i[31]) begin
      b_wins = a_i[31];
    end else if (!a_i[31]) begin
      b_wins = b_i[30:0] > a_i[30:0];
    end else begin
      // Both negative: smaller magnitude is the larger value.
      b_wins = b_i[30:0] < a_i[30:0];
    end
  end

  assign y_o = b_wins ? b_i : a_i;

endmodule

// File: rtl/fp32_row_max.sv
// Streaming row-max reducer: result registered on the edge accepting the closing beat (1 cycle).
// No backpressure; every in_valid beat is consumed, result holds until the next row_start.
module fp32_row_max
  import fp32_pkg::*;
#(
  parameter int T = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_fp32,
  input  logic        row_start,
  input  logic        row_last,
  output logic        max_valid,
  output logic [31:0] max_fp32
);

  localparam int CW = $clog2(T + 1);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e      state_q;
  logic [31:0] running_q;
  logic [CW-1:0] cnt_q;
  logic        nan_q;
  logic        max_valid_q;
  logic [31:0] max_fp32_q;

  logic [31:0] fmax_y;
  logic        take;
  logic [31:0] running_d;
  logic [CW-1:0] cnt_d;
  logic        nan_d;
  logic        close;

  fp32_max2 u_max2 (
    .a_i (running_q),
    .b_i (in_fp32),
    .y_o (fmax_y)
  );

  always_comb begin
    take      = 1'b0;
    running_d = running_q;
    cnt_d     = cnt_q;
    nan_d     = nan_q;
    close     = 1'b0;
    if (in_valid) begin
      if (row_start) begin
        // A start mid-row abandons the open row and seeds a fresh one.
        take      = 1'b1;
        running_d = in_fp32;
        cnt_d     = CW'(1);
        nan_d     = is_nan(in_fp32);
      end else if (state_q == ACCUM) begin
        take      = 1'b1;
        running_d = fmax_y;
        cnt_d     = cnt_q + 1'b1;
        nan_d     = nan_q | is_nan(in_fp32);
      end
      close = take && (row_last || (cnt_d == CW'(T)));
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      running_q   <= FP32_POS_ZERO;
      cnt_q       <= '0;
      nan_q       <= 1'b0;
      max_valid_q <= 1'b0;
      max_fp32_q  <= FP32_POS_ZERO;
    end else if (take) begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      nan_q     <= nan_d;
      if (close) begin
        state_q     <= IDLE;
        max_valid_q <= 1'b1;
        max_fp32_q  <= nan_d ? FP32_QNAN : running_d;
      end else begin
        state_q <= ACCUM;
        if (row_start) max_valid_q <= 1'b0;
      end
    end
  end

  assign max_valid = max_valid_q;
  assign max_fp32  = max_fp32_q;

endmodule

// File: tb/tb_fp32_row_max.sv
// Directed-vector bench for fp32_row_max with hand-computed row maxima.
module tb_fp32_row_max;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_fp32;
  logic        row_start;
  logic        row_last;
  logic        max_valid;
  logic [31:0] max_fp32;

  int checks = 0;
  int errors = 0;

  fp32_row_max #(.T(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_fp32   (in_fp32),
    .row_start (row_start),
    .row_last  (row_last),
    .max_valid (max_valid),
    .max_fp32  (max_fp32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Present one beat for one edge; outputs are sampled 1 time unit after that edge.
  task automatic send(input logic [31:0] v, input logic s, input logic l);
    in_valid  = 1'b1;
    in_fp32   = v;
    row_start = s;
    row_last  = l;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    row_start = 1'b0;
    row_last  = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      in_fp32 = 32'hDEAD_BEEF;
      row_start = 1'b1;
      row_last  = 1'b1;
      @(posedge clk);
      #1;
    end
    row_start = 1'b0;
    row_last  = 1'b0;
  endtask

  task automatic row4(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    send(a, 1'b1, 1'b0);
    send(b, 1'b0, 1'b0);
    send(c, 1'b0, 1'b0);
    send(d, 1'b0, 1'b1);
  endtask

  initial begin
    in_valid  = 1'b0;
    in_fp32   = 32'h0;
    row_start = 1'b0;
    row_last  = 1'b0;
    rst_n     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, max_valid}, 32'd0);
    chk("reset_max", max_fp32, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    send(32'h3DCCCCCD, 1'b1, 1'b0);
    send(32'h3ECCCCCD, 1'b0, 1'b0);
    send(32'h3E4CCCCD, 1'b0, 1'b0);
    chk("rowA_not_yet_valid", {31'd0, max_valid}, 32'd0);
    send(32'h3E99999A, 1'b0, 1'b1);
    chk("rowA_valid", {31'd0, max_valid}, 32'd1);
    chk("rowA_max", max_fp32, 32'h3ECCCCCD);

    send(32'hBF800000, 1'b1, 1'b0);
    chk("rowB_start_clears_valid", {31'd0, max_valid}, 32'd0);
    chk("rowB_start_keeps_old_max", max_fp32, 32'h3ECCCCCD);
    send(32'hBF000000, 1'b0, 1'b0);
    send(32'hC0000000, 1'b0, 1'b0);
    send(32'hBE800000, 1'b0, 1'b1);
    chk("rowB_valid", {31'd0, max_valid}, 32'd1);
    chk("rowB_max_neg", max_fp32, 32'hBE800000);

    send(32'h40A00000, 1'b1, 1'b0);
    chk("rowC_b2b_clears_valid", {31'd0, max_valid}, 32'd0);
    send(32'h40400000, 1'b0, 1'b0);
    send(32'h40E00000, 1'b0, 1'b0);
    send(32'h40C00000, 1'b0, 1'b1);
    chk("rowC_max", max_fp32, 32'h40E00000);
    gap(2);
    chk("rowC_hold_valid", {31'd0, max_valid}, 32'd1);
    chk("rowC_hold_max", max_fp32, 32'h40E00000);

    row4(32'h80000000, 32'h00000000, 32'hC0400000, 32'hBF800000);
    chk("zeros_first_kept", max_fp32, 32'h80000000);

    row4(32'h7F800000, 32'h3F800000, 32'h40000000, 32'h40400000);
    chk("pos_inf", max_fp32, 32'h7F800000);

    row4(32'h3F800000, 32'h7FC00001, 32'h40000000, 32'h40400000);
    chk("nan_canonical", max_fp32, 32'h7FC00000);

    row4(32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000);
    chk("nan_flag_cleared", max_fp32, 32'h40000000);

    send(32'h3F800000, 1'b1, 1'b1);
    chk("single_valid", {31'd0, max_valid}, 32'd1);
    chk("single_max", max_fp32, 32'h3F800000);

    send(32'h3F800000, 1'b1, 1'b0);
    send(32'h40000000, 1'b0, 1'b0);
    send(32'h40400000, 1'b0, 1'b0);
    send(32'h40800000, 1'b0, 1'b0);
    chk("forced_close_valid", {31'd0, max_valid}, 32'd1);
    chk("forced_close_max", max_fp32, 32'h40800000);

    send(32'h41000000, 1'b0, 1'b1);
    chk("idle_drop_valid", {31'd0, max_valid}, 32'd1);
    chk("idle_drop_max", max_fp32, 32'h40800000);

    send(32'h40000000, 1'b1, 1'b0);
    gap(1);
    send(32'h41100000, 1'b0, 1'b0);
    gap(2);
    send(32'h40400000, 1'b0, 1'b1);
    chk("gaps_valid", {31'd0, max_valid}, 32'd1);
    chk("gaps_max", max_fp32, 32'h41100000);

    send(32'h3F800000, 1'b1, 1'b0);
    send(32'h40000000, 1'b0, 1'b0);
    send(32'h3F000000, 1'b1, 1'b0);
    chk("abort_no_result", {31'd0, max_valid}, 32'd0);
    send(32'h3E800000, 1'b0, 1'b1);
    chk("abort_new_row_max", max_fp32, 32'h3F000000);

    send(32'h40A00000, 1'b1, 1'b0);
    send(32'h40E00000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("midrow_reset_valid", {31'd0, max_valid}, 32'd0);
    chk("midrow_reset_max", max_fp32, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    send(32'h40000000, 1'b0, 1'b1);
    chk("post_reset_idle_drop", {31'd0, max_valid}, 32'd0);
    row4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    chk("post_reset_valid", {31'd0, max_valid}, 32'd1);
    chk("post_reset_max", max_fp32, 32'h40800000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_row_max.md
Name: fp32_row_max

Overview:
- Streaming reducer that returns the maximum of one row of IEEE-754 binary32 values, one element per valid beat.
- Sits in the attention-score path ahead of softmax, where the row max is subtracted before exponentiation.
- Row length is nominally T. Rows are framed by row_start and row_last strobes.

Parameters:
- T, 4, nominal elements per row; a row is force-closed on its T-th accepted element.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- in_valid  in  1  element beat valid.
- in_fp32  in  32  element value, binary32.
- row_start  in  1  qualified by in_valid; this beat is the first element of a new row.
- row_last  in  1  qualified by in_valid; this beat is the last element of the row.
- max_valid  out  1  row result available.
- max_fp32  out  32  row maximum, binary32.

Behaviour:
- Reset (async assert): max_valid=0, max_fp32=32'h0, running max=0, element count=0, state=IDLE.
- Beats with in_valid=0 are ignored; row_start and row_last are don't-care on those beats.
- There is no backpressure. Every in_valid beat is accepted.
- States:
  - IDLE: beats without row_start are dropped. A beat with row_start loads the running max with in_fp32, sets count=1, and moves to ACCUM.
  - ACCUM: each beat updates running max = fmax(running, in_fp32) and increments count.
- A beat with row_start in ACCUM aborts the current row with no result. That beat reloads the running max as a new first element.
- A row closes on the beat with row_last=1, or on the beat that makes count==T, whichever comes first.
  - On close, state returns to IDLE.
  - Single-element row (row_start and row_last on the same beat): that element is the result.
- Latency: on the clock edge that accepts the closing beat, max_fp32 is registered with the final max (including the closing element) and max_valid is set to 1.
  - The result is visible the cycle after the last element is presented.
- max_valid and max_fp32 hold until the next accepted row_start beat, which clears max_valid on that edge.
  - max_fp32 keeps its old value until overwritten by the next close.
  - Back-to-back rows are allowed: a new row_start on the cycle right after row_last works.
- Comparison fmax(a,b), using sign-magnitude ordering:
  - Both non-negative: the larger raw bits wins.
  - Both negative: the smaller raw bits wins.
  - Mixed signs: the non-negative value wins.
  - +0 and -0 compare equal.
  - On any tie, keep the incumbent (running) value.
  - Denormals and infinities need no special case; the ordering handles them.
- NaN: if any element of the row is a NaN (exp=8'hFF, frac!=0), the result is the canonical quiet NaN 32'h7FC00000. A sticky per-row flag tracks this and is cleared at row_start.
- The comparator is purely combinational; one stage of registers holds running, count, nan flag, state and the outputs.
- Reset asserted mid-row discards the row with no result.

Decomposition:
- Package fp32_pkg holds:
  - constants FP32_QNAN=32'h7FC00000, FP32_EXP_MAX=8'hFF, FP32_POS_ZERO=32'h0;
  - helper functions is_nan() and is_zero().
- One combinational sub-module fp32_max2 (inputs a, b; output y = fmax per the rules above, ties returning a). Instantiate it once with a = running max and b = in_fp32.

Test Plan:
- Row [0.1,0.4,0.2,0.3] = 3DCCCCCD,3ECCCCCD,3E4CCCCD,3E99999A, row_start on beat 0, row_last on beat 3 -> one cycle after beat 3, max_valid=1 and max_fp32=3ECCCCCD (0.4).
- Row [-1,-0.5,-2,-0.25] = BF800000,BF000000,C0000000,BE800000 -> max_fp32=BE800000 (-0.25). Checks negative ordering.
- Row [5,3,7,6] = 40A00000,40400000,40E00000,40C00000 -> 40E00000 (7). Run directly after the previous row; max_valid must drop at that row's row_start.
- Mixed and edge values:
  - [-0.0, +0.0, -3, -1] -> 80000000, the first of two equal zeros kept.
  - [+inf, 1, 2, 3] -> 7F800000.
  - [1, 7FC00001, 2, 3] -> 7FC00000.
- Framing:
  - single-element row 3F800000 (start+last same beat) -> 3F800000 next cycle;
  - a row with no row_last closes at the 4th beat;
  - a beat without row_start in IDLE is ignored;
  - in_valid gaps mid-row do not affect the result.
- Reset asserted mid-row -> max_valid=0 and max_fp32=0 immediately; the next full row gives a correct result.
